// File: rtl/mmio_store_monitor.sv
// mmio_store_monitor
//   Watches a processor store bus. Aligned stores that fall inside the
//   address window [WIN_LO, WIN_HI] are queued in a show-ahead FIFO that a
//   consumer drains through a valid/ready handshake. The block also counts
//   every store, flags dropped (overflow) and misaligned stores, and
//   decides the test outcome from the first store to PASS_ADDR.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-low reset
//   we_mem     : store strobe, one store per high cycle
//   addr_mem   : store byte address
//   write_data : store data
//   out_valid  : FIFO head valid
//   out_ready  : consumer accepts the head
//   out_addr   : head address (0 until the first push after reset)
//   out_data   : head data    (0 until the first push after reset)
//   fifo_count : FIFO occupancy
//   store_cnt  : saturating count of all stores
//   overflow   : sticky, an in-window aligned store was dropped
//   misalign   : sticky, a store had addr_mem[1:0] != 0
//   done       : test result has been written
//   pass       : test result equalled PASS_DATA
module mmio_store_monitor #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] WIN_LO    = 32'd64,
  parameter logic [31:0] WIN_HI    = 32'd127,
  parameter logic [31:0] PASS_ADDR = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'd7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_mem,
  input  logic [31:0]              addr_mem,
  input  logic [31:0]              write_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              store_cnt,
  output logic                     overflow,
  output logic                     misalign,
  output logic                     done,
  output logic                     pass
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 64;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;

  // Status
  logic [31:0]      store_cnt_q, store_cnt_d;
  logic             overflow_q, overflow_d;
  logic             misalign_q, misalign_d;

  // Result FSM
  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  // Store classification
  logic aligned;
  logic in_win;
  logic full;
  logic pop;
  logic eligible;
  logic push;
  logic drop;

  // Classify the current store and the handshake on the FIFO head
  always_comb begin
    aligned  = (addr_mem[1:0] == 2'b00);
    in_win   = (addr_mem >= WIN_LO) && (addr_mem <= WIN_HI);
    full     = (count_q == CNT_W'(DEPTH));
    pop      = out_valid_q && out_ready;
    eligible = we_mem && aligned && in_win;
    // A full FIFO still accepts a store when the head leaves on the same edge
    push     = eligible && (!full || pop);
    drop     = eligible && full && !pop;
  end

  // FIFO next state; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {addr_mem, write_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != CNT_W'(0));
  end

  // Store counter and sticky error flags
  always_comb begin
    store_cnt_d = store_cnt_q;
    if (we_mem && (store_cnt_q != 32'hFFFF_FFFF)) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end
    overflow_d = overflow_q | drop;
    misalign_d = misalign_q | (we_mem && !aligned);
  end

  // Result FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Result FSM: next state; only the first store to PASS_ADDR decides
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RUN) && we_mem && (addr_mem == PASS_ADDR)) begin
      state_d = (write_data == PASS_DATA) ? ST_PASS : ST_FAIL;
    end
  end

  // Result FSM: outputs, decoded from next state so the flops track the state
  always_comb begin
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      store_cnt_q <= '0;
      overflow_q  <= 1'b0;
      misalign_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      store_cnt_q <= store_cnt_d;
      overflow_q  <= overflow_d;
      misalign_q  <= misalign_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Show-ahead head; storage is cleared on reset so the head reads 0 until a push
  assign out_valid  = out_valid_q;
  assign out_addr   = mem_q[rd_ptr_q][63:32];
  assign out_data   = mem_q[rd_ptr_q][31:0];
  assign fifo_count = count_q;
  assign store_cnt  = store_cnt_q;
  assign overflow   = overflow_q;
  assign misalign   = misalign_q;
  assign done       = done_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_mmio_store_monitor.sv
// Testbench for mmio_store_monitor: vector table plus hand-written sequences,
// with a scoreboard queue holding the expected FIFO output order.
module tb_mmio_store_monitor;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_mem;
  logic [31:0] addr_mem;
  logic [31:0] write_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  fifo_count;
  logic [31:0] store_cnt;
  logic        overflow;
  logic        misalign;
  logic        done;
  logic        pass;

  mmio_store_monitor #(
    .DEPTH(DEPTH), .WIN_LO(32'd64), .WIN_HI(32'd127),
    .PASS_ADDR(32'd84), .PASS_DATA(32'd7)
  ) dut (
    .clk(clk), .rst(rst), .we_mem(we_mem), .addr_mem(addr_mem),
    .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .fifo_count(fifo_count),
    .store_cnt(store_cnt), .overflow(overflow), .misalign(misalign),
    .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    int          exp_cnt;
    logic        exp_valid;
    logic        exp_ovf;
    logic        exp_mis;
    logic        exp_done;
    logic        exp_pass;
    int          exp_sc;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [63:0] sb[$];
  int          m_sc;
  logic        m_ovf, m_mis, m_done, m_pass;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_sc = 0; m_ovf = 0; m_mis = 0; m_done = 0; m_pass = 0;
  endtask

  // One bus cycle: drive at negedge, check the popped head before the edge,
  // check status after the edge.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    logic        do_pop, was_full, elig;
    logic [63:0] e;
    @(negedge clk);
    we_mem = w; addr_mem = a; write_data = d; out_ready = r;
    #1;
    check("out_valid", out_valid, sb.size() != 0);
    do_pop   = (sb.size() != 0) && r;
    was_full = (sb.size() == DEPTH);
    if (do_pop) begin
      e = sb.pop_front();
      check("out_addr", out_addr, e[63:32]);
      check("out_data", out_data, e[31:0]);
      last_data = e[31:0];
    end
    elig = w && (a[1:0] == 2'b00) && (a >= 32'd64) && (a <= 32'd127);
    if (elig && (!was_full || do_pop)) sb.push_back({a, d});
    if (elig && was_full && !do_pop) m_ovf = 1'b1;
    if (w && a[1:0] != 2'b00) m_mis = 1'b1;
    if (w) m_sc++;
    if (w && a == 32'd84 && !m_done) begin
      m_done = 1'b1;
      m_pass = (d == 32'd7);
    end
    @(posedge clk);
    #1;
    check("fifo_count", fifo_count, sb.size());
    check("overflow", overflow, m_ovf);
    check("misalign", misalign, m_mis);
    check("store_cnt", store_cnt, m_sc);
    check("done", done, m_done);
    check("pass", pass, m_pass);
  endtask

  // One reset cycle with an optional concurrent store and ready
  task automatic do_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b0; we_mem = w; addr_mem = a; write_data = d; out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check("rst out_valid", out_valid, 1'b0);
    check("rst fifo_count", fifo_count, 0);
    check("rst out_addr", out_addr, 0);
    check("rst out_data", out_data, 0);
    check("rst store_cnt", store_cnt, 0);
    check("rst overflow", overflow, 1'b0);
    check("rst misalign", misalign, 1'b0);
    check("rst done", done, 1'b0);
    check("rst pass", pass, 1'b0);
    @(negedge clk);
    rst = 1'b1; we_mem = 1'b0; addr_mem = '0; write_data = '0; out_ready = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    rst = 1'b0; we_mem = 1'b0; addr_mem = '0; write_data = '0; out_ready = 1'b0;
    model_clear();
    last_data = '0;

    //          we  addr    data  rdy cnt vld ovf mis dn  ps  sc
    vecs[0] = '{1'b1, 32'd64,  32'd5, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'd0,   32'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{1'b1, 32'd84,  32'd7, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[3] = '{1'b1, 32'd84,  32'd3, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[4] = '{1'b0, 32'd0,   32'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[5] = '{1'b1, 32'd66,  32'd1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4};
    vecs[6] = '{1'b1, 32'd200, 32'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5};
    vecs[7] = '{1'b1, 32'd128, 32'd3, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6};
    vecs[8] = '{1'b0, 32'd0,   32'd0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6};

    repeat (2) @(posedge clk);
    do_reset(1'b0, 32'd0, 32'd0);

    // Table: single-entry latency, pass/fail decision, misaligned and out-of-window
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy);
      check($sformatf("vec%0d cnt", i), fifo_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d ovf", i), overflow, vecs[i].exp_ovf);
      check($sformatf("vec%0d mis", i), misalign, vecs[i].exp_mis);
      check($sformatf("vec%0d done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d pass", i), pass, vecs[i].exp_pass);
      check($sformatf("vec%0d sc", i), store_cnt, vecs[i].exp_sc);
    end

    // Fill past capacity with the consumer stalled, then drain in order
    do_reset(1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 9; i++) step(1'b1, 32'd68, 32'(i), 1'b0);
    check("ovf full cnt", fifo_count, 8);
    check("ovf sticky", overflow, 1'b1);
    check("ovf head stable", out_data, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
    check("ovf drained", fifo_count, 0);
    check("ovf last", last_data, 32'd8);

    // Full FIFO with simultaneous push and pop keeps its count
    do_reset(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'd72, 32'(10 + i), 1'b0);
    step(1'b1, 32'd72, 32'd99, 1'b1);
    check("pp full cnt", fifo_count, 8);
    check("pp no ovf", overflow, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
    check("pp last", last_data, 32'd99);

    // Count 1 with push and pop: the new entry becomes head
    step(1'b1, 32'd76, 32'd40, 1'b0);
    step(1'b1, 32'd80, 32'd41, 1'b1);
    check("pp1 cnt", fifo_count, 1);
    check("pp1 head", out_data, 32'd41);
    step(1'b0, 32'd0, 32'd0, 1'b1);

    // Reset with entries queued and a concurrent store
    for (int i = 0; i < 3; i++) step(1'b1, 32'd64, 32'(20 + i), 1'b0);
    do_reset(1'b1, 32'd64, 32'd55);
    step(1'b1, 32'd88, 32'd1, 1'b0);
    check("post-rst head", out_data, 32'd1);
    check("post-rst cnt", fifo_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_store_monitor.md
MMIO_STORE_MONITOR -- requirements
Module: mmio_store_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter WIN_LO, default 32'd64: lowest captured byte address, inclusive.
REQ-003 SHALL have parameter WIN_HI, default 32'd127: highest captured byte address, inclusive.
REQ-004 SHALL have parameter PASS_ADDR, default 32'd84: test-result address.
REQ-005 SHALL have parameter PASS_DATA, default 32'd7: test-pass value.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port we_mem, input, 1: processor store strobe; each high cycle is one store.
REQ-009 SHALL have port addr_mem, input, 32: store byte address.
REQ-010 SHALL have port write_data, input, 32: store data.
REQ-011 SHALL have port out_valid, output, 1: FIFO head valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the head.
REQ-013 SHALL have port out_addr, output, 32: head address.
REQ-014 SHALL have port out_data, output, 32: head data.
REQ-015 SHALL have port fifo_count, output, $clog2(DEPTH)+1: occupancy.
REQ-016 SHALL have port store_cnt, output, 32: total stores seen.
REQ-017 SHALL have port overflow, output, 1: sticky; an in-window store was dropped.
REQ-018 SHALL have port misalign, output, 1: sticky; a store had addr_mem[1:0]!=0.
REQ-019 SHALL have port done, output, 1: the test result has been written.
REQ-020 SHALL have port pass, output, 1: the test result equalled PASS_DATA.

Function
REQ-021 SHALL treat a store as captured when we_mem=1, addr_mem[1:0]=0, WIN_LO<=addr_mem<=WIN_HI, and the FIFO is not full (or full with a pop in the same cycle).
REQ-022 SHALL push {addr_mem, write_data} on the edge ending the store cycle; out_valid SHALL rise one cycle after the store cycle (latency 1).
REQ-023 SHALL present the head show-ahead: out_addr/out_data valid whenever out_valid=1; pop SHALL occur on the edge where out_valid&&out_ready.
REQ-024 SHALL keep out_addr/out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL ignore out_ready when empty: no pop, fifo_count stays 0.
REQ-026 SHALL, on push and pop in the same cycle, leave fifo_count unchanged, including when full (push accepted) or at count 1 (new entry becomes head).
REQ-027 SHALL, on an in-window aligned store when full with no pop, drop the store and set overflow; FIFO contents unchanged.
REQ-028 SHALL wrap read/write pointers modulo DEPTH.
REQ-029 SHALL not capture a store with addr_mem[1:0]!=0, and SHALL set misalign for it regardless of window.
REQ-030 SHALL increment store_cnt on every we_mem=1 cycle, saturating at 32'hFFFF_FFFF.
REQ-031 SHALL run a result FSM with states RUN, PASS, FAIL; reset state RUN.
REQ-032 SHALL move RUN->PASS on a store to PASS_ADDR with write_data==PASS_DATA, and RUN->FAIL on a store to PASS_ADDR with any other data.
REQ-033 SHALL hold PASS and FAIL until reset; later stores to PASS_ADDR SHALL not change the state.
REQ-034 SHALL drive done=1 in PASS or FAIL, pass=1 only in PASS, both registered and updated one cycle after the deciding store.
REQ-035 SHALL capture the PASS_ADDR store in the FIFO too when it lies in the window.

Reset
REQ-036 SHALL, while rst=0 at a rising edge, clear pointers, fifo_count=0, out_valid=0, store_cnt=0, overflow=0, misalign=0, done=0, pass=0, FSM=RUN.
REQ-037 SHALL give reset priority over a simultaneous store or pop; the store SHALL not be captured or counted.
REQ-038 SHALL drive out_addr/out_data to 0 during and after reset until the first push.

Verification
REQ-039 SHALL cover: store addr 64 data 5, out_ready=1 -> out_valid high exactly 1 cycle after store, out_addr=64, out_data=5, fifo_count back to 0.
REQ-040 SHALL cover: out_ready=0, 9 stores to addr 68 data 1..9 (DEPTH=8) -> fifo_count=8, overflow=1, drain yields data 1..8 in order.
REQ-041 SHALL cover: FIFO full, out_ready=1 and store addr 72 data 99 same cycle -> fifo_count stays 8, overflow=0, 99 emerges last.
REQ-042 SHALL cover: store addr 84 data 7 then addr 84 data 3 -> done=1, pass=1 after first, unchanged after second; store_cnt=2.
REQ-043 SHALL cover: store addr 66 and store addr 200 -> misalign=1, neither captured, store_cnt=2, fifo_count=0.
REQ-044 SHALL cover: rst=0 for one cycle with 3 entries queued and a concurrent store -> all outputs at reset values next cycle, store_cnt=0.
